// File: rtl/halt_controller.sv
// Halt controller: freezes fetch on a CU HALT or an external halt request, drains the pipeline,
// holds HALTED until a resume request, then releases. Optional halt counter via HALT_STATS_EN.
module halt_controller #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned NUM_EXT      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               is_halt_i,
    input  logic [NUM_EXT-1:0] ext_halt_req_i,
    input  logic               resume_req_i,
    output logic               freeze_o,
    output logic               halted_o,
    output logic               resume_ack_o,
    output logic [NUM_EXT:0]   halt_cause_o,
    output logic [1:0]         state_dbg_o
`ifdef HALT_STATS_EN
    ,
    output logic [15:0]        halt_count_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NUM_EXT:0] cause_q;
    logic             halted_q;
    logic             ack_q;
    logic [NUM_EXT:0] req_vec;
    logic             any_req;

    assign req_vec = {ext_halt_req_i, is_halt_i};
    assign any_req = |req_vec;

    // Zero-latency freeze in RUN so the HALT in ID never advances; RESUME deliberately drops it.
    assign freeze_o = ((state_q == S_RUN) && any_req)
                    || (state_q == S_DRAIN)
                    || (state_q == S_HALTED);

    assign halted_o     = halted_q;
    assign resume_ack_o = ack_q;
    assign halt_cause_o = cause_q;
    assign state_dbg_o  = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            cause_q  <= '0;
            halted_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (any_req) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
                        cause_q <= cause_q | req_vec;
                    end
                end
                S_DRAIN: begin
                    cause_q <= cause_q | req_vec;
                    // Leave on the edge where the count reaches zero, so HALTED lands DRAIN_CYCLES after acceptance.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q  <= S_HALTED;
                        cnt_q    <= '0;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HALTED: begin
                    cause_q <= cause_q | req_vec;
                    if (resume_req_i) begin
                        state_q  <= S_RESUME;
                        halted_q <= 1'b0;
                        ack_q    <= 1'b1;
                    end
                end
                S_RESUME: begin
                    state_q <= S_RUN;
                    cause_q <= '0;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q  <= S_RUN;
                    cnt_q    <= '0;
                    cause_q  <= '0;
                    halted_q <= 1'b0;
                    ack_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef HALT_STATS_EN
    logic [15:0] halt_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_count_q <= '0;
        end else if ((state_q == S_RUN) && any_req && (halt_count_q != 16'hFFFF)) begin
            halt_count_q <= halt_count_q + 16'd1;
        end
    end

    assign halt_count_o = halt_count_q;
`endif

endmodule

// File: tb/tb_halt_controller.sv
// Bench for halt_controller (DRAIN_CYCLES=3, NUM_EXT=2): directed vector table, hand-written
// reset corner sequences, and randomized stimulus against a cycle-count reference model.
module tb_halt_controller;

    localparam int D  = 3;
    localparam int NE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          is_halt;
    logic [NE-1:0] ext;
    logic          resume;
    logic          freeze, halted, ack;
    logic [NE:0]   cause;
    logic [1:0]    state_dbg;
`ifdef HALT_STATS_EN
    logic [15:0]   hcount;
`endif

    halt_controller #(.DRAIN_CYCLES(D), .NUM_EXT(NE)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .is_halt_i      (is_halt),
        .ext_halt_req_i (ext),
        .resume_req_i   (resume),
        .freeze_o       (freeze),
        .halted_o       (halted),
        .resume_ack_o   (ack),
        .halt_cause_o   (cause),
        .state_dbg_o    (state_dbg)
`ifdef HALT_STATS_EN
        ,
        .halt_count_o   (hcount)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic f, input logic h, input logic a,
                           input logic [NE:0] c);
        chk({tag, ".freeze"}, 32'(freeze), 32'(f));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
        chk({tag, ".ack"},    32'(ack),    32'(a));
        chk({tag, ".cause"},  32'(cause),  32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: counts cycles since the accepting edge instead of tracking named states.
    int          m_since;   // -1 while running, else cycles elapsed since acceptance
    bit          m_res;     // currently in the one-cycle resume window
    logic [NE:0] m_cause;
    int          m_count;

    task automatic model_reset();
        m_since = -1;
        m_res   = 1'b0;
        m_cause = '0;
        m_count = 0;
    endtask

    function automatic logic m_halted();
        return (m_since >= D);
    endfunction

    function automatic logic m_freeze();
        return !m_res && ((m_since >= 1) || is_halt || (ext != '0));
    endfunction

    task automatic model_step();
        logic [NE:0] req;
        req = {ext, is_halt};
        if (rst) begin
            model_reset();
        end else if (m_res) begin
            m_res   = 1'b0;
            m_since = -1;
            m_cause = '0;
        end else if (m_since < 0) begin
            if (req != '0) begin
                m_since = 1;
                m_cause = m_cause | req;
                if (m_count < 65535) m_count++;
            end
        end else begin
            m_cause = m_cause | req;
            if (m_halted() && resume) begin
                m_res   = 1'b1;
                m_since = -1;
            end else if (!m_halted()) begin
                m_since++;
            end
        end
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        is_halt = 1'b0;
        ext     = '0;
        resume  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0, '0);
        is_halt = 1'b1;
        #1;
        chk("reset.freeze_comb", 32'(freeze), 32'd1);
        is_halt = 1'b0;
        rst     = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          ih;
        logic [NE-1:0] ex;
        logic          rs;
        logic          f;
        logic          h;
        logic          a;
        logic [NE:0]   c;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ih, input logic [NE-1:0] ex, input logic rs,
                       input logic f, input logic h, input logic a, input logic [NE:0] c);
        vec_t v;
        v.ih = ih; v.ex = ex; v.rs = rs;
        v.f  = f;  v.h  = h;  v.a  = a; v.c = c;
        vecs.push_back(v);
    endtask

    initial begin
        rst     = 1'b1;
        is_halt = 1'b0;
        ext     = '0;
        resume  = 1'b0;
        model_reset();

        // Each row: inputs held during one cycle, outputs expected in that same cycle.
        add(0, 2'b00, 0, 0, 0, 0, 3'b000);  // idle
        add(1, 2'b00, 0, 1, 0, 0, 3'b000);  // CU HALT accepted
        add(1, 2'b00, 0, 1, 0, 0, 3'b001);
        add(1, 2'b00, 0, 1, 0, 0, 3'b001);
        add(1, 2'b00, 0, 1, 1, 0, 3'b001);  // halted 3 cycles later
        add(1, 2'b00, 1, 1, 1, 0, 3'b001);  // resume pulse
        add(1, 2'b00, 0, 0, 0, 1, 3'b001);  // resume window ignores HALT
        add(0, 2'b00, 0, 0, 0, 0, 3'b000);  // back to RUN, cause cleared
        add(0, 2'b10, 0, 1, 0, 0, 3'b000);  // ext[1] accepted
        add(0, 2'b00, 0, 1, 0, 0, 3'b100);
        add(1, 2'b00, 0, 1, 0, 0, 3'b100);  // late CU HALT merged
        add(0, 2'b00, 0, 1, 1, 0, 3'b101);  // timing unchanged
        add(0, 2'b00, 1, 1, 1, 0, 3'b101);
        add(0, 2'b00, 0, 0, 0, 1, 3'b101);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000);
        add(0, 2'b00, 1, 0, 0, 0, 3'b000);  // resume in RUN ignored
        add(0, 2'b01, 0, 1, 0, 0, 3'b000);  // ext[0] accepted
        add(0, 2'b00, 1, 1, 0, 0, 3'b010);  // resume in DRAIN ignored
        add(0, 2'b00, 0, 1, 0, 0, 3'b010);
        add(0, 2'b00, 0, 1, 1, 0, 3'b010);
        add(0, 2'b00, 0, 1, 1, 0, 3'b010);  // stays halted, no remembered resume
        add(0, 2'b00, 1, 1, 1, 0, 3'b010);
        add(0, 2'b01, 0, 0, 0, 1, 3'b010);  // held ext ignored in resume window
        add(0, 2'b01, 0, 1, 0, 0, 3'b000);  // first RUN cycle re-freezes
        add(0, 2'b01, 0, 1, 0, 0, 3'b010);  // DRAIN again

        reset_dut();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            is_halt = vecs[i].ih;
            ext     = vecs[i].ex;
            resume  = vecs[i].rs;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].f, vecs[i].h, vecs[i].a, vecs[i].c);
        end

        // Reset asserted mid-DRAIN aborts the halt.
        reset_dut();
        tick(); is_halt = 1'b1;
        tick(); is_halt = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_out("rst_drain", 1'b0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk_out("rst_drain_after", 1'b0, 1'b0, 1'b0, 3'b000);
        end

        // Reset during the resume window drops the acknowledge; held ext re-halts normally.
        reset_dut();
        tick(); ext = 2'b01;
        tick(); tick(); tick();
        chk("rr.halted", 32'(halted), 32'd1);
        resume = 1'b1;
        tick(); resume = 1'b0;
        chk("rr.ack", 32'(ack), 32'd1);
        rst = 1'b1;
        #1;
        chk_out("rr.rst", 1'b1, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_out("rr.d1", 1'b1, 1'b0, 1'b0, 3'b010);
        tick();
        chk_out("rr.d2", 1'b1, 1'b0, 1'b0, 3'b010);
        tick();
        chk_out("rr.h", 1'b1, 1'b1, 1'b0, 3'b010);
        ext = '0;

        // Randomized run against the reference model, including occasional async resets.
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            model_step();
            #1;
            rst     = ($urandom_range(0, 79) == 0);
            is_halt = ($urandom_range(0, 5) == 0);
            ext[0]  = ($urandom_range(0, 7) == 0);
            ext[1]  = ($urandom_range(0, 9) == 0);
            resume  = ($urandom_range(0, 2) == 0);
            if (rst) model_reset();
            @(negedge clk);
            chk_out("rand", m_freeze(), m_halted(), m_res, m_cause);
`ifdef HALT_STATS_EN
            chk("rand.count", 32'(hcount), 32'(m_count));
`endif
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/halt_controller.md
HALT_CONTROLLER -- requirements
Module: halt_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles from halt acceptance to halted_o assertion (legal range 1..15).
REQ-002 SHALL have parameter NUM_EXT, default 2, meaning the number of external halt-request channels (legal range 1..8).
REQ-003 SHALL have port clk_i, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port is_halt_i, input, 1, HALT decoded by the Control Unit.
REQ-006 SHALL have port ext_halt_req_i, input, NUM_EXT, level-sensitive external/debug halt requests.
REQ-007 SHALL have port resume_req_i, input, 1, single-cycle resume request.
REQ-008 SHALL have port freeze_o, output, 1, freeze to PC and IF/ID register.
REQ-009 SHALL have port halted_o, output, 1, pipeline drained and stopped.
REQ-010 SHALL have port resume_ack_o, output, 1, one-cycle resume acknowledge.
REQ-011 SHALL have port halt_cause_o, output, NUM_EXT+1, latched cause: bit0 = CU HALT, bit k = ext_halt_req_i[k-1].

Function
REQ-012 SHALL implement four states: RUN, DRAIN, HALTED and RESUME.
REQ-013 freeze_o SHALL equal (state==RUN & (is_halt_i | |ext_halt_req_i)) | state==DRAIN | state==HALTED, with zero-cycle latency from the request in RUN.
REQ-014 RUN: any request SHALL move to DRAIN, load the drain counter with DRAIN_CYCLES-1 and OR the requesting sources into the cause register.
REQ-015 DRAIN: the counter SHALL decrement each cycle; at counter==0 the state SHALL move to HALTED, so halted_o rises exactly DRAIN_CYCLES cycles after the accepting edge.
REQ-016 DRAIN/HALTED: newly asserted requests SHALL be ORed into halt_cause_o and SHALL NOT restart the counter.
REQ-017 HALTED: halted_o = 1; resume_req_i SHALL move to RESUME.
REQ-018 resume_req_i in RUN, DRAIN or RESUME SHALL be ignored and not remembered.
REQ-019 RESUME: freeze_o = 0 and resume_ack_o = 1 for exactly one cycle; is_halt_i and ext_halt_req_i SHALL be ignored in that cycle, so the frozen HALT instruction in ID is passed.
REQ-020 RESUME: the next state SHALL be RUN and the cause register SHALL clear.
REQ-021 An ext request still high in the first RUN cycle after RESUME SHALL re-enter DRAIN.
REQ-022 halted_o SHALL be 1 only in HALTED, and resume_ack_o only in RESUME.
REQ-023 Counter width SHALL be $clog2(DRAIN_CYCLES+1) bits, unsigned, with no wrap in legal operation.

Reset
REQ-024 rst_i SHALL force, asynchronously, state = RUN, counter = 0 and cause = 0.
REQ-025 After reset, outputs SHALL be halted_o = 0, resume_ack_o = 0 and halt_cause_o = 0; freeze_o SHALL follow REQ-013 combinationally.
REQ-026 Reset asserted in any state, including mid-DRAIN or RESUME, SHALL abort the operation with no pending resume or cause retained.

Configuration
REQ-027 With macro HALT_STATS_EN defined, the block SHALL add output halt_count_o, 16 bits, incrementing on each RUN->DRAIN transition and saturating at 0xFFFF.
REQ-028 halt_count_o SHALL reset to 0.
REQ-029 With HALT_STATS_EN undefined, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (DRAIN_CYCLES=3, NUM_EXT=2)
REQ-030 is_halt_i=1 at cycle 0 -> freeze_o=1 in cycle 0; halted_o=1 from cycle 3; halt_cause_o=3'b001.
REQ-031 In HALTED with is_halt_i held 1, pulse resume_req_i -> next cycle resume_ack_o=1 and freeze_o=0; then RUN; halt_cause_o=0.
REQ-032 ext_halt_req_i=2'b10 enters DRAIN; at the DRAIN counter's second cycle is_halt_i=1 -> halt_cause_o=3'b101; halted_o timing unchanged (3 cycles).
REQ-033 resume_req_i pulsed in RUN and in DRAIN -> no effect; halted_o still reached after 3 cycles and held.
REQ-034 ext_halt_req_i=2'b01 held through resume -> one RESUME cycle, one RUN cycle with freeze_o=1, DRAIN again; HALT_STATS_EN build shows halt_count_o=2.
REQ-035 rst_i asserted mid-DRAIN (counter=1) -> immediately halted_o=0, halt_cause_o=0, state RUN; freeze_o=0 with inputs low.
